// File: rtl/adb_controller.sv
// ADB transceiver behind the VIA shift register: decodes host commands and answers
// Talk requests for a keyboard (addr 2) and a mouse (addr 3); Listen data is discarded.
module adb_controller (
    input  logic       clk32,
    input  logic       _systemReset,
    input  logic       clk_en,
    input  logic [1:0] st,
    input  logic       viaBusy,
    input  logic [7:0] adb_din,
    input  logic       adb_din_strobe,
    input  logic       mouseStrobe,
    input  logic [8:0] mouseX,
    input  logic [8:0] mouseY,
    input  logic       mouseButton,
    input  logic       keyStrobe,
    input  logic [7:0] keyData,
    output logic       _int,
    output logic       listen,
    output logic [7:0] adb_dout,
    output logic       adb_dout_strobe
);
    localparam logic [1:0] ST_CMD  = 2'b00;
    localparam logic [1:0] ST_EVEN = 2'b01;
    localparam logic [1:0] ST_ODD  = 2'b10;
    localparam logic [3:0] KBD_ADDR   = 4'd2;
    localparam logic [3:0] MOUSE_ADDR = 4'd3;

    logic [1:0]      st_last_q, st_last_d;
    logic            armed_q, armed_d, tx_pend_q, tx_pend_d, timeout_q, timeout_d;
    logic [7:0]      cmd_q, cmd_d, dout_q, dout_d;
    logic            dout_stb_q, dout_stb_d, int_q, int_d;
    logic [3:0][7:0] fifo_q, fifo_d;
    logic [2:0]      cnt_q, cnt_d, cnt_pop;
    logic [6:0]      dx_q, dx_d, dy_q, dy_d, base_x, base_y;
    logic            last_btn_q, last_btn_d;
    logic signed [10:0] sum_x, sum_y;

    logic       entry, fresh, in_data, is_talk, is_listen, kbd_pend, mouse_pend;
    logic       has_data, tmo, tmo_now, srq, send, pop, clr_mouse, flush_kbd;
    logic [3:0] addr;
    logic [1:0] reg_n;

    function automatic logic [6:0] sat7(input logic signed [10:0] v);
        if (v > 11'sd63)       return 7'h3F;
        else if (v < -11'sd64) return 7'h40;
        else                   return v[6:0];
    endfunction

    assign entry      = clk_en && (st != st_last_q);
    // Timeout is decided when the talk starts; an odd-byte entry reached via the
    // even byte reuses that decision.
    assign fresh      = entry && ((st == ST_EVEN) || (st_last_q != ST_EVEN));
    assign in_data    = (st == ST_EVEN) || (st == ST_ODD);
    assign addr       = cmd_q[7:4];
    assign reg_n      = cmd_q[1:0];
    assign is_talk    = cmd_q[3:2] == 2'b11;
    assign is_listen  = cmd_q[3:2] == 2'b10;
    assign kbd_pend   = cnt_q != 3'd0;
    assign mouse_pend = (dx_q != 7'd0) || (dy_q != 7'd0) || (mouseButton != last_btn_q);
    assign has_data   = ((reg_n == 2'd3) && (addr == KBD_ADDR || addr == MOUSE_ADDR)) ||
                        ((reg_n == 2'd0) && ((addr == KBD_ADDR && kbd_pend) ||
                                             (addr == MOUSE_ADDR && mouse_pend)));
    assign tmo        = is_talk && !has_data;
    assign srq        = (kbd_pend && addr != KBD_ADDR) || (mouse_pend && addr != MOUSE_ADDR);

    always_comb begin
        st_last_d  = st_last_q;
        armed_d    = armed_q;
        tx_pend_d  = tx_pend_q;
        timeout_d  = timeout_q;
        cmd_d      = cmd_q;
        dout_d     = dout_q;
        dout_stb_d = dout_stb_q;
        last_btn_d = last_btn_q;
        pop        = 1'b0;
        clr_mouse  = 1'b0;
        flush_kbd  = 1'b0;
        tmo_now    = fresh ? tmo : timeout_q;
        send       = clk_en && in_data && !viaBusy && (entry ? is_talk : tx_pend_q);

        if (clk_en) begin
            st_last_d  = st;
            dout_stb_d = 1'b0;
        end
        if (entry) begin
            if (st == ST_CMD) begin
                armed_d   = 1'b1;
                tx_pend_d = 1'b0;
                timeout_d = 1'b0;
            end else if (in_data) begin
                armed_d   = is_listen;
                tx_pend_d = is_talk;
                if (fresh) timeout_d = tmo;
            end else begin
                armed_d   = 1'b0;
                tx_pend_d = 1'b0;
            end
        end

        if (send) begin
            dout_stb_d = 1'b1;
            tx_pend_d  = 1'b0;
            if (tmo_now) begin
                dout_d = 8'hFF;
            end else if (reg_n == 2'd3) begin
                dout_d = (st == ST_EVEN) ? {4'h6, addr} : ((addr == KBD_ADDR) ? 8'h02 : 8'h01);
            end else if (addr == KBD_ADDR) begin
                dout_d = kbd_pend ? fifo_q[0] : 8'hFF;
                pop    = kbd_pend;
            end else if (st == ST_EVEN) begin
                dout_d     = {mouseButton, dy_q};
                last_btn_d = mouseButton;
            end else begin
                dout_d    = {1'b1, dx_q};
                clr_mouse = 1'b1;
            end
        end

        if (clk_en && adb_din_strobe && armed_q && !entry) begin
            armed_d = 1'b0;
            if (st == ST_CMD) begin
                cmd_d = adb_din;
                // SendReset / Flush drop whatever the addressed device had queued
                if (adb_din[3:1] == 3'b000) begin
                    flush_kbd = adb_din[7:4] == KBD_ADDR;
                    if (adb_din[7:4] == MOUSE_ADDR) begin
                        clr_mouse  = 1'b1;
                        last_btn_d = mouseButton;
                    end
                end
            end
        end

        // Pop before push so a key arriving with a read is not lost on a full FIFO
        cnt_pop = cnt_q - {2'b00, pop};
        fifo_d  = pop ? {8'hFF, fifo_q[3:1]} : fifo_q;
        cnt_d   = cnt_pop;
        if (clk_en && keyStrobe && cnt_pop < 3'd4) begin
            fifo_d[cnt_pop[1:0]] = keyData;
            cnt_d                = cnt_pop + 3'd1;
        end
        if (flush_kbd) cnt_d = 3'd0;

        base_x = clr_mouse ? 7'd0 : dx_q;
        base_y = clr_mouse ? 7'd0 : dy_q;
        sum_x  = {{4{base_x[6]}}, base_x} + {{2{mouseX[8]}}, mouseX};
        sum_y  = {{4{base_y[6]}}, base_y} - {{2{mouseY[8]}}, mouseY};
        dx_d   = base_x;
        dy_d   = base_y;
        if (clk_en && mouseStrobe) begin
            dx_d = sat7(sum_x);
            dy_d = sat7(sum_y);
        end

        case (st)
            ST_CMD:  int_d = 1'b1;
            ST_EVEN,
            ST_ODD:  int_d = !timeout_q;
            default: int_d = !srq;
        endcase
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            st_last_q  <= ST_CMD;
            armed_q    <= 1'b0;
            tx_pend_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cmd_q      <= 8'h00;
            dout_q     <= 8'hFF;
            dout_stb_q <= 1'b0;
            int_q      <= 1'b1;
            fifo_q     <= '0;
            cnt_q      <= 3'd0;
            dx_q       <= 7'd0;
            dy_q       <= 7'd0;
            last_btn_q <= 1'b1;
        end else begin
            st_last_q  <= st_last_d;
            armed_q    <= armed_d;
            tx_pend_q  <= tx_pend_d;
            timeout_q  <= timeout_d;
            cmd_q      <= cmd_d;
            dout_q     <= dout_d;
            dout_stb_q <= dout_stb_d;
            int_q      <= int_d;
            fifo_q     <= fifo_d;
            cnt_q      <= cnt_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            last_btn_q <= last_btn_d;
        end
    end

    assign _int            = int_q;
    assign listen          = armed_q && !viaBusy;
    assign adb_dout        = dout_q;
    assign adb_dout_strobe = dout_stb_q;
endmodule

// File: tb/tb_adb_controller.sv
// Randomized bench for adb_controller: an abstract device model queues the expected
// response bytes, and a monitor compares them against every adb_dout_strobe pulse.
`timescale 1ns/1ps
module tb_adb_controller;
    logic       clk32 = 1'b0;
    logic       _systemReset = 1'b0;
    logic       clk_en;
    logic [1:0] st = 2'b11;
    logic       viaBusy = 1'b0;
    logic [7:0] adb_din = 8'h00;
    logic       adb_din_strobe = 1'b0;
    logic       mouseStrobe = 1'b0;
    logic [8:0] mouseX = 9'd0, mouseY = 9'd0;
    logic       mouseButton = 1'b1;
    logic       keyStrobe = 1'b0;
    logic [7:0] keyData = 8'h00;
    logic       _int, listen, adb_dout_strobe;
    logic [7:0] adb_dout;
    logic [1:0] en_cnt = 2'd0;

    int checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] kq[$];
    int  mdx = 0, mdy = 0, last_addr = 0;
    bit  mlast = 1'b1;

    adb_controller dut (
        .clk32(clk32), ._systemReset(_systemReset), .clk_en(clk_en), .st(st),
        .viaBusy(viaBusy), .adb_din(adb_din), .adb_din_strobe(adb_din_strobe),
        .mouseStrobe(mouseStrobe), .mouseX(mouseX), .mouseY(mouseY),
        .mouseButton(mouseButton), .keyStrobe(keyStrobe), .keyData(keyData),
        ._int(_int), .listen(listen), .adb_dout(adb_dout), .adb_dout_strobe(adb_dout_strobe)
    );

    always #5 clk32 = ~clk32;
    always @(posedge clk32) en_cnt <= en_cnt + 2'd1;
    assign clk_en = (en_cnt == 2'd0);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one 8 MHz enable: return just after the next enabled clock edge
    task automatic step();
        do @(posedge clk32); while (!clk_en);
        #1;
    endtask

    function automatic int clamp(input int v);
        return (v > 63) ? 63 : (v < -64) ? -64 : v;
    endfunction

    function automatic bit srq_model();
        bit mpend;
        mpend = (mdx != 0) || (mdy != 0) || (mouseButton != mlast);
        return (kq.size() > 0 && last_addr != 2) || (mpend && last_addr != 3);
    endfunction

    task automatic mouse_model(input int x, input int y);
        mdx = clamp(mdx + x);
        mdy = clamp(mdy - y);
    endtask

    task automatic key(input logic [7:0] v);
        keyData = v; keyStrobe = 1'b1; step(); keyStrobe = 1'b0;
        if (kq.size() < 4) kq.push_back(v);
    endtask

    task automatic mouse(input int x, input int y);
        mouseX = 9'(x); mouseY = 9'(y); mouseStrobe = 1'b1; step(); mouseStrobe = 1'b0;
        mouse_model(x, y);
    endtask

    task automatic model_cmd(input logic [7:0] cmd, output bit tmo, output bit talk, output bit lsn);
        int a, r;
        logic [6:0] x7, y7;
        a = int'(cmd[7:4]);
        r = int'(cmd[1:0]);
        last_addr = a;
        if (cmd[3:1] == 3'b000) begin
            if (a == 2) kq.delete();
            if (a == 3) begin mdx = 0; mdy = 0; mlast = mouseButton; end
        end
        talk = (cmd[3:2] == 2'b11);
        lsn  = (cmd[3:2] == 2'b10);
        tmo  = 1'b0;
        if (!talk) return;
        if (r == 3 && (a == 2 || a == 3)) begin
            exp_q.push_back(8'h60 | 8'(a));
            exp_q.push_back((a == 2) ? 8'h02 : 8'h01);
        end else if (r == 0 && a == 2 && kq.size() > 0) begin
            exp_q.push_back(kq.pop_front());
            exp_q.push_back(kq.size() > 0 ? kq.pop_front() : 8'hFF);
        end else if (r == 0 && a == 3 && (mdx != 0 || mdy != 0 || mouseButton != mlast)) begin
            y7 = mdy[6:0];
            x7 = mdx[6:0];
            exp_q.push_back({mouseButton, y7});
            exp_q.push_back({1'b1, x7});
            mlast = mouseButton; mdx = 0; mdy = 0;
        end else begin
            tmo = 1'b1;
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFF);
        end
    endtask

    // side: 1 = key strobe on the byte0 enable, 2 = mouse strobe on the byte1 enable
    task automatic txn(input logic [7:0] cmd, input bit bf, input int side, input int sx, input int sy);
        bit tmo, talk, lsn;
        st = 2'b00; step(); step();
        chk("listen_armed", listen, 1);
        chk("int_cmd", _int, 1);
        adb_din = cmd; adb_din_strobe = 1'b1; step(); adb_din_strobe = 1'b0;
        chk("listen_drop", listen, 0);
        model_cmd(cmd, tmo, talk, lsn);
        for (int ph = 1; ph <= 2; ph++) begin
            st = 2'(ph); viaBusy = bf;
            if (side == 1 && ph == 1) begin keyData = 8'(sx); keyStrobe = 1'b1; end
            if (side == 2 && ph == 2) begin mouseX = 9'(sx); mouseY = 9'(sy); mouseStrobe = 1'b1; end
            step();
            keyStrobe = 1'b0; mouseStrobe = 1'b0;
            if (side == 1 && ph == 1 && kq.size() < 4) kq.push_back(8'(sx));
            if (side == 2 && ph == 2) mouse_model(sx, sy);
            if (bf) chk("listen_busy", listen, 0);
            viaBusy = 1'b0; step(); step();
            chk("listen_data", listen, int'(lsn));
            if (lsn) begin
                adb_din = 8'($urandom); adb_din_strobe = 1'b1; step(); adb_din_strobe = 1'b0;
                chk("listen_done", listen, 0);
            end
            chk("int_data", _int, int'(!(talk && tmo)));
            viaBusy = 1'b1; step(); viaBusy = 1'b0; step();
        end
        st = 2'b11; step(); step();
        chk("int_idle", _int, int'(!srq_model()));
    endtask

    // scoreboard monitor: one expected byte per rising strobe
    initial begin
        logic prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk32);
            if (adb_dout_strobe && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got %02h with nothing expected", adb_dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout_byte", adb_dout, e);
                end
            end
            prev = adb_dout_strobe;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pool [11];
        pool = '{8'h2C, 8'h3C, 8'h2F, 8'h3F, 8'h2D, 8'h4C, 8'h21, 8'h31, 8'h2B, 8'h3B, 8'h3E};

        repeat (3) step();
        chk("rst_int", _int, 1);
        chk("rst_listen", listen, 0);
        chk("rst_dout", adb_dout, 8'hFF);
        chk("rst_stb", adb_dout_strobe, 0);
        _systemReset = 1'b1;
        step(); step();

        key(8'h0E); key(8'h8E);
        txn(8'h2C, 0, 0, 0, 0);
        mouseButton = 1'b0;
        mouse(5, -3);
        txn(8'h3C, 0, 0, 0, 0);
        txn(8'h3C, 0, 0, 0, 0);
        mouse(100, 0); mouse(100, 0);
        txn(8'h3C, 1, 0, 0, 0);
        mouseButton = 1'b1;
        txn(8'h2F, 0, 0, 0, 0);
        txn(8'h3F, 1, 0, 0, 0);
        txn(8'h3C, 0, 0, 0, 0);
        key(8'h12);
        txn(8'h3F, 0, 0, 0, 0);
        txn(8'h2C, 0, 0, 0, 0);
        txn(8'h2B, 0, 0, 0, 0);
        txn(8'h2B, 1, 0, 0, 0);
        key(8'h01); key(8'h02); key(8'h03); key(8'h04); key(8'h05);
        txn(8'h2C, 0, 1, 8'h06, 0);
        txn(8'h2C, 0, 0, 0, 0);
        mouse(3, 3);
        txn(8'h3C, 0, 2, 10, -4);
        txn(8'h3C, 0, 0, 0, 0);
        key(8'h22);
        txn(8'h21, 0, 0, 0, 0);
        txn(8'h2C, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: key(8'($urandom));
                1: mouse(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
                2: begin mouseButton = 1'($urandom_range(0, 1)); step(); end
                default: txn(pool[$urandom_range(0, 10)], 1'($urandom_range(0, 1)), 0, 0, 0);
            endcase
        end

        mouseButton = 1'b1;
        key(8'h41); key(8'h42); key(8'h43);
        st = 2'b00; step(); step();
        begin
            bit t0, t1, t2;
            adb_din = 8'h2C; adb_din_strobe = 1'b1; step(); adb_din_strobe = 1'b0;
            model_cmd(8'h2C, t0, t1, t2);
        end
        st = 2'b01; step(); step();
        _systemReset = 1'b0;
        #1;
        chk("midrst_dout", adb_dout, 8'hFF);
        chk("midrst_stb", adb_dout_strobe, 0);
        chk("midrst_int", _int, 1);
        chk("midrst_listen", listen, 0);
        exp_q.delete(); kq.delete();
        mdx = 0; mdy = 0; mlast = 1'b1; last_addr = 0;
        step(); st = 2'b11; step();
        _systemReset = 1'b1;
        step(); step();
        txn(8'h2C, 0, 0, 0, 0);
        txn(8'h3F, 0, 0, 0, 0);

        repeat (4) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adb_controller.md
ADB_CONTROLLER -- requirements
Module: adb_controller

Interface
REQ-001 clk32  input  1  system clock; all logic on rising edge.
REQ-002 _systemReset  input  1  reset, asynchronous, active-low.
REQ-003 clk_en  input  1  8 MHz enable; state advances only when high.
REQ-004 st  input  2  VIA ADB state: 00 command, 01 even byte, 10 odd byte, 11 idle.
REQ-005 viaBusy  input  1  VIA shift register busy; high while a byte is being shifted.
REQ-006 adb_din / adb_din_strobe  input  8/1  byte received from the host; strobe is a 1-enable pulse.
REQ-007 mouseStrobe, mouseX, mouseY, mouseButton  input  1/9/9/1  mouse movement packet; X/Y are signed two's complement; button is low when pressed.
REQ-008 keyStrobe, keyData  input  1/8  ADB keycode event; keyData bit7=1 means release.
REQ-009 _int  output  1  active-low interrupt/status to VIA PB3.
REQ-010 listen  output  1  high when the controller expects a byte from the host.
REQ-011 adb_dout / adb_dout_strobe  output  8/1  response byte to the host; strobe is a 1-enable pulse.

Function
REQ-012 Command byte format: addr[7:4], cmd[3:2], reg[1:0]; cmd 11=Talk, 10=Listen; 0000 SendReset and 0001 Flush clear the addressed device's pending data.
REQ-013 Devices: keyboard at address 2, handler 0x02; mouse at address 3, handler 0x01; other addresses give no response.
REQ-014 On entry to st=00 the controller arms command reception.
REQ-015 listen=1 while armed and !viaBusy; listen drops on the enable after adb_din_strobe, and the byte is latched as the current command.
REQ-016 Talk data, byte0 and byte1: each is presented exactly once per state entry.
REQ-017 Talk byte0 is presented on the first enable after st becomes 01 with viaBusy=0; it is placed on adb_dout with adb_dout_strobe=1 for one enable.
REQ-018 Talk byte1 is presented the same way on entry to st=10.
REQ-019 Keyboard Talk R0: byte0 = oldest FIFO keycode, byte1 = next keycode, or 0xFF if none; both are popped.
REQ-020 Keyboard FIFO: 4 entries; a keyStrobe when full is dropped.
REQ-021 Mouse Talk R0: byte0 = {mouseButton, dY[6:0]}, byte1 = {1'b1, dX[6:0]}; the accumulators are cleared after byte1.
REQ-022 Mouse accumulators: each mouseStrobe adds mouseX to dX and -mouseY to dY; the result saturates to -64..+63.
REQ-023 Mouse pending = dX≠0 or dY≠0 or mouseButton differs from the last reported value.
REQ-024 Talk R3: byte0 = 0x60|addr, byte1 = handler ID.
REQ-025 Talk to a device with nothing pending (R0), to an unknown address, or to R1/R2: adb_dout=0xFF, and _int=0 during st 01/10 (timeout).
REQ-026 Listen: listen=1 on entry to st=01 and on entry to st=10 until a byte arrives.
REQ-027 Listen data is accepted and discarded.
REQ-028 _int in st=11: low if any device other than the last-addressed device has pending data (service request); otherwise high.
REQ-029 _int in st=00: high.
REQ-030 Simultaneous keyStrobe and a FIFO pop: the pop happens first, then the push.
REQ-031 Simultaneous mouseStrobe and a clear: the new delta is retained.

Reset
REQ-032 While _systemReset=0: _int=1, listen=0, adb_dout=0xFF, adb_dout_strobe=0, FIFO empty, dX=dY=0, last button=1, command=0x00, disarmed.
REQ-033 Reset asserted in mid-transaction aborts the transaction.
REQ-034 After release, the controller waits for the next st=00.

Verification
REQ-035 st=00, host sends 0x2C (kbd Talk R0) after keyStrobe 0x0E, 0x8E; st=01 -> dout 0x0E; st=10 -> dout 0x8E; _int=1.
REQ-036 mouseStrobe X=+5, Y=-3, button=0; Talk 0x3C -> bytes 0x03, 0x85; a second Talk 0x3C -> 0xFF with _int=0 in st 01.
REQ-037 mouseX=+200 across strobes -> byte1=0xBF (saturated +63).
REQ-038 Talk 0x2F -> 0x62, 0x02.
REQ-039 Talk 0x3F -> 0x63, 0x01.
REQ-040 Key pending, last command to mouse, st=11 -> _int=0.
REQ-041 Listen 0x2B -> listen=1 in st 01 and in st 10 until each strobe.
REQ-042 Reset asserted mid-Talk -> outputs return to their reset values immediately.
